// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: pops ps2_keyboard FIFO bytes, strips E0/F0 prefixes and emits one key event per make/break.
module ps2_kbd_ctrl #(
  parameter int CNT_W       = 8,
  parameter bit REPEAT_EMIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_ovf,
  output logic             err_byte,
  input  logic             clr_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ev_valid_q, ev_valid_d;
  logic [7:0]       ev_code_q, ev_code_d;
  logic             ev_ext_q, ev_ext_d;
  logic             ev_break_q, ev_break_d;
  logic             ev_repeat_q, ev_repeat_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic             cur_ext_q, cur_ext_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_byte_q, err_byte_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             ovf_prev_q;
  logic             same_key, is_rep;
  assign same_key = (byte_q == cur_code_q) && (ext_pend_q == cur_ext_q);
  assign is_rep   = !brk_pend_q && key_down_q && same_key;
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    ev_valid_d   = ev_valid_q;
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_break_d   = ev_break_q;
    ev_repeat_d  = ev_repeat_q;
    key_down_d   = key_down_q;
    cur_code_d   = cur_code_q;
    cur_ext_d    = cur_ext_q;
    press_cnt_d  = press_cnt_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    err_ovf_d    = clr_err ? 1'b0 : err_ovf_q;
    err_byte_d   = clr_err ? 1'b0 : err_byte_q;
    case (state_q)
      IDLE: if (kbd_ready) begin
        byte_d       = kbd_data;
        nextdata_n_d = 1'b0;
        state_d      = POP;
      end
      POP: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        if (byte_q == 8'hE0) ext_pend_d = 1'b1;
        else if (byte_q == 8'hF0) brk_pend_d = 1'b1;
        else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (byte_q == 8'h00 || byte_q == 8'hFF) err_byte_d = 1'b1;
          else if (REPEAT_EMIT || !is_rep) begin
            state_d     = EMIT;
            ev_valid_d  = 1'b1;
            ev_code_d   = byte_q;
            ev_ext_d    = ext_pend_q;
            ev_break_d  = brk_pend_q;
            ev_repeat_d = is_rep;
            if (brk_pend_q) key_down_d = key_down_q && !same_key;
            else begin
              key_down_d  = 1'b1;
              cur_code_d  = byte_q;
              cur_ext_d   = ext_pend_q;
              press_cnt_d = is_rep ? press_cnt_q : press_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      EMIT: if (ev_ready) begin
        ev_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // an overflow means bytes were lost, so any pending prefix no longer applies
    if (kbd_overflow && !ovf_prev_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
    if (kbd_overflow) err_ovf_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      nextdata_n_q <= 1'b1;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= '0;
      ev_ext_q     <= 1'b0;
      ev_break_q   <= 1'b0;
      ev_repeat_q  <= 1'b0;
      key_down_q   <= 1'b0;
      cur_code_q   <= '0;
      cur_ext_q    <= 1'b0;
      press_cnt_q  <= '0;
      err_ovf_q    <= 1'b0;
      err_byte_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      ovf_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_break_q   <= ev_break_d;
      ev_repeat_q  <= ev_repeat_d;
      key_down_q   <= key_down_d;
      cur_code_q   <= cur_code_d;
      cur_ext_q    <= cur_ext_d;
      press_cnt_q  <= press_cnt_d;
      err_ovf_q    <= err_ovf_d;
      err_byte_q   <= err_byte_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      ovf_prev_q   <= kbd_overflow;
    end
  end
  assign kbd_nextdata_n = nextdata_n_q;
  assign ev_valid       = ev_valid_q;
  assign ev_code        = ev_code_q;
  assign ev_ext         = ev_ext_q;
  assign ev_break       = ev_break_q;
  assign ev_repeat      = ev_repeat_q;
  assign key_down       = key_down_q;
  assign cur_code       = cur_code_q;
  assign cur_ext        = cur_ext_q;
  assign press_cnt      = press_cnt_q;
  assign err_ovf        = err_ovf_q;
  assign err_byte       = err_byte_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed vectors for ps2_kbd_ctrl; instance 0 default, 1 drops repeats, 2 has a 2-bit counter.
module tb_ps2_kbd_ctrl;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ev_t;
  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    ev_t        ev;
    logic       kd;
    logic [7:0] cc;
    logic       cx;
    logic [7:0] pc;
  } vec_t;
  logic       clk, rst, kbd_overflow, ev_ready, clr_err;
  logic [7:0] kd[3], ec[3], cc[3];
  logic       kr[3], nd[3], evv[3], ee[3], eb[3], er[3], kdn[3], cx[3], eo[3], ebt[3];
  logic [7:0] pc0, pc1;
  logic [1:0] pc2;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  ev_t        lg0[$], lg1[$], lg2[$];
  int         low0;
  int         n_pass = 0, n_tot = 0;
  vec_t       tbl[10];
  ps2_kbd_ctrl #(.CNT_W(8), .REPEAT_EMIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .kbd_data(kd[0]), .kbd_ready(kr[0]), .kbd_overflow(kbd_overflow),
    .kbd_nextdata_n(nd[0]), .ev_valid(evv[0]), .ev_ready(ev_ready), .ev_code(ec[0]),
    .ev_ext(ee[0]), .ev_break(eb[0]), .ev_repeat(er[0]), .key_down(kdn[0]), .cur_code(cc[0]),
    .cur_ext(cx[0]), .press_cnt(pc0), .err_ovf(eo[0]), .err_byte(ebt[0]), .clr_err(clr_err));
  ps2_kbd_ctrl #(.CNT_W(8), .REPEAT_EMIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .kbd_data(kd[1]), .kbd_ready(kr[1]), .kbd_overflow(kbd_overflow),
    .kbd_nextdata_n(nd[1]), .ev_valid(evv[1]), .ev_ready(ev_ready), .ev_code(ec[1]),
    .ev_ext(ee[1]), .ev_break(eb[1]), .ev_repeat(er[1]), .key_down(kdn[1]), .cur_code(cc[1]),
    .cur_ext(cx[1]), .press_cnt(pc1), .err_ovf(eo[1]), .err_byte(ebt[1]), .clr_err(clr_err));
  ps2_kbd_ctrl #(.CNT_W(2), .REPEAT_EMIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .kbd_data(kd[2]), .kbd_ready(kr[2]), .kbd_overflow(kbd_overflow),
    .kbd_nextdata_n(nd[2]), .ev_valid(evv[2]), .ev_ready(ev_ready), .ev_code(ec[2]),
    .ev_ext(ee[2]), .ev_break(eb[2]), .ev_repeat(er[2]), .key_down(kdn[2]), .cur_code(cc[2]),
    .cur_ext(cx[2]), .press_cnt(pc2), .err_ovf(eo[2]), .err_byte(ebt[2]), .clr_err(clr_err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // keyboard FIFO models: pop on an edge with nextdata_n low, head visible from the next negedge
  always @(posedge clk) begin
    if (!nd[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (!nd[1] && fq1.size() > 0) void'(fq1.pop_front());
    if (!nd[2] && fq2.size() > 0) void'(fq2.pop_front());
  end
  always @(negedge clk) begin
    kr[0] = fq0.size() > 0;
    kd[0] = kr[0] ? fq0[0] : 8'h00;
    kr[1] = fq1.size() > 0;
    kd[1] = kr[1] ? fq1[0] : 8'h00;
    kr[2] = fq2.size() > 0;
    kd[2] = kr[2] ? fq2[0] : 8'h00;
    if (evv[0] && ev_ready) lg0.push_back('{ec[0], ee[0], eb[0], er[0]});
    if (evv[1] && ev_ready) lg1.push_back('{ec[1], ee[1], eb[1], er[1]});
    if (evv[2] && ev_ready) lg2.push_back('{ec[2], ee[2], eb[2], er[2]});
    if (!nd[0]) low0++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic int lsz(input int w);
    return w == 0 ? lg0.size() : w == 1 ? lg1.size() : lg2.size();
  endfunction
  task automatic wait_ev(input int w, input int need);
    int t = 0;
    while (lsz(w) < need && t < 100) begin
      cyc(1);
      t++;
    end
    chk($sformatf("ev_count%0d", w), lsz(w), need);
  endtask
  task automatic wait_valid;
    int t = 0;
    while (!evv[0] && t < 30) begin
      cyc(1);
      t++;
    end
    chk("ev_valid_rise", evv[0], 1);
  endtask
  initial begin
    ev_t e;
    int  stable;
    tbl[0] = '{1, 8'h1C, 8'h00, 8'h00, '{8'h1C, 1'b0, 1'b0, 1'b0}, 1'b1, 8'h1C, 1'b0, 8'd1};
    tbl[1] = '{2, 8'hF0, 8'h1C, 8'h00, '{8'h1C, 1'b0, 1'b1, 1'b0}, 1'b0, 8'h1C, 1'b0, 8'd1};
    tbl[2] = '{2, 8'hE0, 8'h75, 8'h00, '{8'h75, 1'b1, 1'b0, 1'b0}, 1'b1, 8'h75, 1'b1, 8'd2};
    tbl[3] = '{3, 8'hE0, 8'hF0, 8'h75, '{8'h75, 1'b1, 1'b1, 1'b0}, 1'b0, 8'h75, 1'b1, 8'd2};
    tbl[4] = '{1, 8'h1B, 8'h00, 8'h00, '{8'h1B, 1'b0, 1'b0, 1'b0}, 1'b1, 8'h1B, 1'b0, 8'd3};
    tbl[5] = '{1, 8'h1B, 8'h00, 8'h00, '{8'h1B, 1'b0, 1'b0, 1'b1}, 1'b1, 8'h1B, 1'b0, 8'd3};
    tbl[6] = '{1, 8'h1B, 8'h00, 8'h00, '{8'h1B, 1'b0, 1'b0, 1'b1}, 1'b1, 8'h1B, 1'b0, 8'd3};
    tbl[7] = '{2, 8'hF0, 8'h1C, 8'h00, '{8'h1C, 1'b0, 1'b1, 1'b0}, 1'b1, 8'h1B, 1'b0, 8'd3};
    tbl[8] = '{2, 8'hE0, 8'h1B, 8'h00, '{8'h1B, 1'b1, 1'b0, 1'b0}, 1'b1, 8'h1B, 1'b1, 8'd4};
    tbl[9] = '{1, 8'h1B, 8'h00, 8'h00, '{8'h1B, 1'b0, 1'b0, 1'b0}, 1'b1, 8'h1B, 1'b0, 8'd5};
    rst = 1'b0;
    kbd_overflow = 1'b0;
    ev_ready = 1'b1;
    clr_err = 1'b0;
    low0 = 0;
    cyc(3);
    chk("rst_nextdata_n", nd[0], 1);
    chk("rst_ev_valid", evv[0], 0);
    chk("rst_ev_code", ec[0], 0);
    chk("rst_press_cnt", pc0, 0);
    chk("rst_key_down", kdn[0], 0);
    chk("rst_err", {eo[0], ebt[0]}, 0);
    rst = 1'b1;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      low0 = 0;
      fq0.push_back(tbl[i].b0);
      if (tbl[i].n > 1) fq0.push_back(tbl[i].b1);
      if (tbl[i].n > 2) fq0.push_back(tbl[i].b2);
      wait_ev(0, 1);
      if (lg0.size() > 0) begin
        e = lg0.pop_front();
        chk($sformatf("v%0d_event", i), e, tbl[i].ev);
      end
      chk($sformatf("v%0d_key_down", i), kdn[0], tbl[i].kd);
      chk($sformatf("v%0d_cur_code", i), cc[0], tbl[i].cc);
      chk($sformatf("v%0d_cur_ext", i), cx[0], tbl[i].cx);
      chk($sformatf("v%0d_press_cnt", i), pc0, tbl[i].pc);
      chk($sformatf("v%0d_pop_cycles", i), low0, tbl[i].n);
      lg0.delete();
      cyc(2);
    end
    ev_ready = 1'b0;
    low0 = 0;
    fq0.push_back(8'h1C);
    fq0.push_back(8'hF0);
    fq0.push_back(8'h1C);
    wait_valid();
    stable = 0;
    repeat (20) begin
      cyc(1);
      if (evv[0] && ec[0] == 8'h1C) stable++;
    end
    chk("bp_stable", stable, 20);
    chk("bp_single_pop", low0, 1);
    chk("bp_no_accept", lg0.size(), 0);
    ev_ready = 1'b1;
    wait_ev(0, 2);
    if (lg0.size() == 2) begin
      chk("bp_ev0", lg0[0], ev_t'{8'h1C, 1'b0, 1'b0, 1'b0});
      chk("bp_ev1", lg0[1], ev_t'{8'h1C, 1'b0, 1'b1, 1'b0});
    end
    chk("bp_press_cnt", pc0, 6);
    chk("bp_key_down", kdn[0], 0);
    lg0.delete();
    repeat (3) fq1.push_back(8'h1B);
    foreach (tbl[i]) if (i < 5) fq2.push_back(8'h15 + 8'(i * 8));
    cyc(40);
    chk("norep_events", lg1.size(), 1);
    if (lg1.size() > 0) chk("norep_ev", lg1[0], ev_t'{8'h1B, 1'b0, 1'b0, 1'b0});
    chk("norep_press_cnt", pc1, 1);
    wait_ev(2, 5);
    chk("wrap_press_cnt", pc2, 1);
    fq0.push_back(8'hF0);
    cyc(6);
    kbd_overflow = 1'b1;
    cyc(1);
    kbd_overflow = 1'b0;
    chk("ovf_set", eo[0], 1);
    fq0.push_back(8'h1C);
    wait_ev(0, 1);
    if (lg0.size() > 0) chk("ovf_resync_ev", lg0[0], ev_t'{8'h1C, 1'b0, 1'b0, 1'b0});
    chk("ovf_press_cnt", pc0, 7);
    lg0.delete();
    fq0.push_back(8'hFF);
    cyc(10);
    chk("errbyte_set", ebt[0], 1);
    chk("errbyte_no_ev", lg0.size(), 0);
    kbd_overflow = 1'b1;
    clr_err = 1'b1;
    cyc(1);
    chk("clr_set_wins", eo[0], 1);
    kbd_overflow = 1'b0;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_err", {eo[0], ebt[0]}, 0);
    ev_ready = 1'b0;
    fq0.push_back(8'h2C);
    wait_valid();
    cyc(2);
    chk("pre_rst_key_down", kdn[0], 1);
    rst = 1'b0;
    #1;
    chk("arst_ev_valid", evv[0], 0);
    chk("arst_ev_code", ec[0], 0);
    chk("arst_key_down", kdn[0], 0);
    chk("arst_cur_code", cc[0], 0);
    chk("arst_press_cnt", pc0, 0);
    chk("arst_nextdata_n", nd[0], 1);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
